// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared definitions for the serial-to-parallel receiver:
//                FSM state encoding, default word width and a helper that
//                sizes the bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package sipo_pkg;

   // Default number of bits per received word
   localparam int DEFAULT_WIDTH = 4;

   // Receiver FSM states; encoding is fixed so other blocks can decode it
   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   // Bit-counter width for a given word width (word width is always >= 2)
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_shreg
//  Description : WIDTH-bit right shift register. Serial data enters at the
//                MSB so that an LSB-first stream ends up in natural bit order
//                after WIDTH shifts. Synchronous clear has priority over shift.
//  Revision    : 1.0  initial release
// ============================================================================
module sipo_shreg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             clear,
   input  logic             shift,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_data;

   // Shift right with new bit at MSB; sync clear wins so a restart never samples
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_data <= '0;
      end else if (clear) begin
         r_data <= '0;
      end else if (shift) begin
         r_data <= {sin, r_data[WIDTH-1:1]};
      end
   end

   assign q = r_data;

endmodule : sipo_shreg
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_rx
//  Description : Serial-to-parallel receiver. After a start pulse it collects
//                WIDTH bits (LSB first), one per sft strobe, and presents the
//                finished word on dout with a valid/ack handshake. A word that
//                completes while the previous one is still unacknowledged is
//                dropped and the sticky overrun flag is raised.
//  Revision    : 1.0  initial release
// ============================================================================
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             sft,
   input  logic             sin,
   input  logic             ack,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             busy,
   output logic             overrun
);

   localparam int             CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_shreg;
   logic [WIDTH-1:0] w_word;
   logic             w_clear;
   logic             w_shift;
   logic             w_done;
   logic             w_accept;
   logic             w_drop;

   // Shift register holding the partially received word
   sipo_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .clk   (clk),
      .clr   (clr),
      .clear (w_clear),
      .shift (w_shift),
      .sin   (sin),
      .q     (w_shreg)
   );

   // The completed word includes the bit being sampled on the final strobe
   assign w_word = {sin, w_shreg[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath control; start always beats a same-cycle strobe
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RECV;
               w_clear     = 1'b1;
            end
         end
         RECV: begin
            if (start) begin
               w_clear = 1'b1;
            end else if (sft) begin
               w_shift = 1'b1;
               if (r_cnt == C_LAST) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Bit counter: cleared on (re)start and on completion, stepped per sampled bit
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_cnt <= '0;
      end else if (w_clear || w_done) begin
         r_cnt <= '0;
      end else if (w_shift) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A finished word is taken if the output slot is free or being freed now
   assign w_accept = w_done && (!valid || ack);
   assign w_drop   = w_done && valid && !ack;

   // Output word, handshake and sticky overrun flag
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         dout    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (w_accept) begin
            dout  <= w_word;
            valid <= 1'b1;
         end else if (ack) begin
            valid <= 1'b0;
         end
         overrun <= (overrun || w_drop) && !ack;
      end
   end

   assign busy = (r_state == RECV);

endmodule : sipo_rx
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_rx
//  Description : Self-checking bench for sipo_rx (WIDTH=4): a vector table
//                for the basic handshake/overrun paths, hand-written corner
//                sequences and a randomized run against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_rx;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clr;
   logic         start;
   logic         sft;
   logic         sin;
   logic         ack;
   logic [W-1:0] dout;
   logic         valid;
   logic         busy;
   logic         overrun;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: bit count and accumulated value of the current frame
   bit         m_busy;
   int         m_cnt;
   int         m_acc;
   logic [3:0] m_dout;
   bit         m_valid;
   bit         m_ovr;

   typedef struct {
      bit         start;
      bit         sft;
      bit         sin;
      bit         ack;
      logic [3:0] dout;
      bit         valid;
      bit         busy;
      bit         ovr;
   } vec_t;

   vec_t tbl[$];

   sipo_rx #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .sft     (sft),
      .sin     (sin),
      .ack     (ack),
      .dout    (dout),
      .valid   (valid),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input bit s, input bit f, input bit d, input bit a,
                               input logic [3:0] ed, input bit ev, input bit eb, input bit eo);
      vec_t v;
      v.start = s; v.sft = f; v.sin = d; v.ack = a;
      v.dout = ed; v.valid = ev; v.busy = eb; v.ovr = eo;
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] ed, input bit ev,
                        input bit eb, input bit eo);
      n_tests++;
      if (dout !== ed || valid !== ev || busy !== eb || overrun !== eo) begin
         n_fail++;
         $display("FAIL %s: got dout=%h valid=%b busy=%b overrun=%b, want dout=%h valid=%b busy=%b overrun=%b",
                  name, dout, valid, busy, overrun, ed, ev, eb, eo);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_cnt = 0; m_acc = 0; m_dout = '0; m_valid = 0; m_ovr = 0;
   endtask

   // Advance the model by one clock edge from the frame/handshake rules
   task automatic model_step(input bit s, input bit f, input bit d, input bit a);
      bit fin;
      fin = 0;
      if (s) begin
         m_busy = 1; m_cnt = 0; m_acc = 0;
      end else if (m_busy && f) begin
         m_acc = m_acc + (int'(d) << m_cnt);
         m_cnt = m_cnt + 1;
         if (m_cnt == W) begin
            fin = 1; m_busy = 0;
         end
      end
      if (fin) begin
         if (!m_valid || a) begin
            m_dout = 4'(m_acc); m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (a) begin
         m_valid = 0;
      end
      if (a) m_ovr = 0;
   endtask

   // Drive one cycle of inputs (called 1 time unit after an edge), then check model
   task automatic step(input string name, input bit s, input bit f, input bit d, input bit a);
      start = s; sft = f; sin = d; ack = a;
      @(posedge clk);
      #1;
      model_step(s, f, d, a);
      check(name, m_dout, m_valid, m_busy, m_ovr);
   endtask

   initial begin
      clr = 1'b1; start = 0; sft = 0; sin = 0; ack = 0;
      model_reset();
      #2;
      check("reset", 4'h0, 0, 0, 0);
      @(posedge clk); #1;
      clr = 1'b0;

      // start; 1,1,0,1 -> B; ack; B again unacked; 1,0,1,0 -> overrun; ack;
      // B unacked then 5 completes with ack on the same edge
      tbl.push_back(mk(1,0,0,0, 4'h0,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'h0,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'h0,0,1,0));
      tbl.push_back(mk(0,1,0,0, 4'h0,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,0,0));
      tbl.push_back(mk(0,0,0,1, 4'hB,0,0,0));
      tbl.push_back(mk(1,0,0,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,0,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,0,0));
      tbl.push_back(mk(1,0,0,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,0,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,0,0, 4'hB,1,0,1));
      tbl.push_back(mk(0,0,0,1, 4'hB,0,0,0));
      tbl.push_back(mk(1,0,0,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,0,0, 4'hB,0,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,0,0));
      tbl.push_back(mk(1,0,0,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,0,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,1,0, 4'hB,1,1,0));
      tbl.push_back(mk(0,1,0,1, 4'h5,1,0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("model_vec%0d", i), tbl[i].start, tbl[i].sft, tbl[i].sin, tbl[i].ack);
         check($sformatf("vec%0d", i), tbl[i].dout, tbl[i].valid, tbl[i].busy, tbl[i].ovr);
      end

      // Restart mid-frame discards the partial word: two bits, restart, 0,0,1,1 -> C
      step("ack5", 0, 0, 0, 1);
      step("rs_start", 1, 0, 0, 0);
      step("rs_b0", 0, 1, 1, 0);
      step("rs_b1", 0, 1, 1, 0);
      step("rs_restart", 1, 0, 0, 0);
      step("rs_c0", 0, 1, 0, 0);
      step("rs_c1", 0, 1, 0, 0);
      step("rs_c2", 0, 1, 1, 0);
      step("rs_c3", 0, 1, 1, 0);
      check("restart_word", 4'hC, 1, 0, 0);

      // start & sft together: that bit is ignored; strobes separated by idle gaps
      step("ss_ack", 0, 0, 0, 1);
      step("ss_start_sft", 1, 1, 1, 0);
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < 3; g++) step($sformatf("ss_gap%0d_%0d", b, g), 0, 0, 1, 0);
         step($sformatf("ss_bit%0d", b), 0, 1, (b == 1 || b == 2), 0);
      end
      check("gap_word", 4'h6, 1, 0, 0);
      step("idle_sft0", 0, 1, 1, 0);
      step("idle_sft1", 0, 1, 0, 0);
      check("idle_sft_hold", 4'h6, 1, 0, 0);

      // Async clear mid-frame with valid=1: outputs drop before any clock edge
      step("clr_start", 1, 0, 0, 0);
      step("clr_b0", 0, 1, 1, 0);
      clr = 1'b1;
      #2;
      check("async_clr", 4'h0, 0, 0, 0);
      #2;
      clr = 1'b0;
      model_reset();
      start = 0; sft = 0; sin = 0; ack = 0;
      @(posedge clk); #1;
      check("after_clr", 4'h0, 0, 0, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($sformatf("rand%0d", i),
              ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_sipo_rx
`default_nettype wire
